// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer.
//   state_e  : FSM state encoding (hunt for frame sync / run inside a frame)
//   DefaultN : default number of time slots per frame
package tdm_pkg;

  localparam int unsigned DefaultN = 8;

  typedef enum logic {
    StHunt = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demultiplexer.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset, clears the index to 0
//   load_zero_i : wrap to slot 0 (frame completed or sync lost)
//   load_one_i  : restart at slot 1 (frame sync accepted as slot 0)
//   incr_i      : advance to the next slot
//   slot_o      : index of the next slot to be written
module tdm_slot_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_zero_i,
  input  logic          load_one_i,
  input  logic          incr_i,
  output logic [CW-1:0] slot_o
);

  logic [CW-1:0] slot_q;

  // The FSM only asserts incr_i below N-1, so the index never exceeds N-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else if (load_zero_i) begin
      slot_q <= '0;
    end else if (load_one_i) begin
      slot_q <= CW'(1);
    end else if (incr_i) begin
      slot_q <= slot_q + CW'(1);
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer.
// Collects one bit per valid cycle into a shadow register and presents the
// completed frame on q, so partial frames are never visible.
// Ports:
//   clock      : clock, rising edge
//   reset      : synchronous active-high reset
//   din        : serial slot data, sampled when valid
//   valid      : qualifies din and frame_sync
//   frame_sync : with valid, marks din as slot 0
//   q          : last completed frame, slot i on q[i]
//   frame_done : one-cycle pulse when q takes a new frame
//   sync_err   : one-cycle pulse on an early or missing frame sync
//   locked     : high while the FSM is in the run state
//   slot       : index of the next slot to be written
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned N  = DefaultN,
  parameter int unsigned CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          din,
  input  logic          valid,
  input  logic          frame_sync,
  output logic [N-1:0]  q,
  output logic          frame_done,
  output logic          sync_err,
  output logic          locked,
  output logic [CW-1:0] slot
);

  state_e        state_q, state_d;
  // Slot N-1 goes straight from din into q, so only N-1 bits are buffered.
  logic [N-2:0]  shadow_q;
  logic [N-1:0]  frame_q;
  logic          frame_done_q;
  logic          sync_err_q;

  logic          load_zero;
  logic          load_one;
  logic          incr;
  logic          write_shadow;
  logic          complete;
  logic          err_d;
  logic [CW-1:0] wr_idx;
  logic          slot_is_zero;
  logic          slot_is_last;

  assign slot_is_zero = (slot == '0);
  assign slot_is_last = (slot == CW'(N - 1));
  assign wr_idx       = frame_sync ? '0 : slot;

  always_comb begin
    state_d      = state_q;
    load_zero    = 1'b0;
    load_one     = 1'b0;
    incr         = 1'b0;
    write_shadow = 1'b0;
    complete     = 1'b0;
    err_d        = 1'b0;
    if (valid) begin
      if (frame_sync) begin
        // Sync always restarts a frame; mid-frame it also flags the lost frame.
        state_d      = StRun;
        load_one     = 1'b1;
        write_shadow = 1'b1;
        err_d        = (state_q == StRun) && !slot_is_zero;
      end else if (state_q == StRun) begin
        if (slot_is_zero) begin
          // Expected a sync bit here; drop it and go back to hunting.
          state_d = StHunt;
          err_d   = 1'b1;
        end else if (slot_is_last) begin
          complete  = 1'b1;
          load_zero = 1'b1;
        end else begin
          write_shadow = 1'b1;
          incr         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StHunt;
      shadow_q     <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= complete;
      sync_err_q   <= err_d;
      if (write_shadow) begin
        shadow_q[wr_idx] <= din;
      end
      if (complete) begin
        frame_q <= {din, shadow_q};
      end
    end
  end

  tdm_slot_counter #(
    .CW (CW)
  ) u_slot_counter (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_zero_i (load_zero),
    .load_one_i  (load_one),
    .incr_i      (incr),
    .slot_o      (slot)
  );

  assign q          = frame_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == StRun);

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int N  = 8;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          din;
  logic          valid;
  logic          frame_sync;
  logic [N-1:0]  q;
  logic          frame_done;
  logic          sync_err;
  logic          locked;
  logic [CW-1:0] slot;

  int checks = 0;
  int errors = 0;

  tdm_demux #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .valid      (valid),
    .frame_sync (frame_sync),
    .q          (q),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked),
    .slot       (slot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: bits collected since the last accepted sync.
  bit          m_started = 0;
  bit          m_locked  = 0;
  bit          m_bits[$];
  logic [N-1:0] m_q      = '0;
  bit          m_done    = 0;
  bit          m_err     = 0;
  int          done_count = 0;
  int          err_count  = 0;

  always begin
    @(posedge clock);
    if (reset) begin
      m_started = 1;
      m_locked  = 0;
      m_bits.delete();
      m_q       = '0;
      m_done    = 0;
      m_err     = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (valid) begin
        if (frame_sync) begin
          m_err = m_locked && (m_bits.size() != 0);
          m_bits.delete();
          m_bits.push_back(din);
          m_locked = 1;
        end else if (m_locked) begin
          if (m_bits.size() == 0) begin
            m_err    = 1;
            m_locked = 0;
          end else begin
            m_bits.push_back(din);
            if (m_bits.size() == N) begin
              for (int i = 0; i < N; i++) m_q[i] = m_bits[i];
              m_bits.delete();
              m_done = 1;
            end
          end
        end
      end
    end
    #1;
    if (m_started) begin
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_frame_done", 32'(frame_done), 32'(m_done));
      chk("model_sync_err", 32'(sync_err), 32'(m_err));
      chk("model_locked", 32'(locked), 32'(m_locked));
      chk("model_slot", 32'(slot), 32'(m_bits.size()));
      if (frame_done === 1'b1) done_count++;
      if (sync_err === 1'b1) err_count++;
    end
  end

  // Drive one cycle's inputs; returns at the following negedge, after the
  // sampling edge, so outputs reflect these inputs.
  task automatic drive(input logic v, input logic d, input logic s);
    valid      = v;
    din        = d;
    frame_sync = s;
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int i = 0; i < N; i++) drive(1'b1, v[i], i == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset = 1'b1; din = 1'b0; valid = 1'b0; frame_sync = 1'b0;
    @(negedge clock);
    do_reset();
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    chk("reset_slot", 32'(slot), 32'h0);
    chk("reset_done", 32'(frame_done), 32'h0);

    // HUNT ignores unsynced bits.
    drive(1'b1, 1'b1, 1'b0);
    chk("hunt_ignore_slot", 32'(slot), 32'h0);
    chk("hunt_ignore_err", 32'(sync_err), 32'h0);

    // Normal frame.
    send_frame(8'h4D);
    chk("normal_q", 32'(q), 32'h4D);
    chk("normal_done", 32'(frame_done), 32'h1);
    chk("normal_locked", 32'(locked), 32'h1);
    drive(1'b0, 1'b0, 1'b0);
    chk("normal_done_pulse", 32'(frame_done), 32'h0);

    // Back-to-back frames, valid continuous.
    d0 = done_count;
    err_count = 0;
    send_frame(8'h4D);
    send_frame(8'hA5);
    chk("b2b_q", 32'(q), 32'hA5);
    chk("b2b_done_count", 32'(done_count - d0), 32'd2);
    chk("b2b_no_err", 32'(err_count), 32'd0);

    // Early sync at slot 5; the sync bit itself starts the 8'hFF frame.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, i == 0);
    chk("early_slot5", 32'(slot), 32'd5);
    drive(1'b1, 1'b1, 1'b1);
    chk("early_err", 32'(sync_err), 32'h1);
    chk("early_slot", 32'(slot), 32'd1);
    chk("early_q_hold", 32'(q), 32'hA5);
    for (int i = 1; i < N; i++) drive(1'b1, 1'b1, 1'b0);
    chk("early_q_ff", 32'(q), 32'hFF);
    chk("early_done", 32'(frame_done), 32'h1);

    // Missing sync after completion.
    drive(1'b1, 1'b0, 1'b0);
    chk("miss_err", 32'(sync_err), 32'h1);
    chk("miss_locked", 32'(locked), 32'h0);
    chk("miss_q", 32'(q), 32'hFF);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("miss_ignored_slot", 32'(slot), 32'h0);
    chk("miss_ignored_err", 32'(sync_err), 32'h0);

    // Valid gap between slots 3 and 4.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h4D >> i, i == 0);
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 1'b1, 1'b1);
      chk("gap_slot", 32'(slot), 32'd4);
      chk("gap_q", 32'(q), 32'hFF);
    end
    for (int i = 4; i < N; i++) drive(1'b1, 8'h4D >> i, 1'b0);
    chk("gap_frame_q", 32'(q), 32'h4D);

    // Reset mid-frame.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i == 0);
    chk("rst_mid_slot", 32'(slot), 32'd4);
    do_reset();
    chk("rst_mid_q", 32'(q), 32'h0);
    chk("rst_mid_slot0", 32'(slot), 32'h0);
    chk("rst_mid_locked", 32'(locked), 32'h0);
    d0 = done_count;
    for (int i = 4; i < N; i++) drive(1'b1, 1'b1, 1'b0);
    chk("rst_mid_no_done", 32'(done_count - d0), 32'd0);
    chk("rst_mid_q_hold", 32'(q), 32'h0);
    send_frame(8'h3C);
    chk("rst_mid_q3c", 32'(q), 32'h3C);
    chk("rst_mid_done_count", 32'(done_count - d0), 32'd1);

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter N, default 8: number of time slots per frame; legal range 2..16.
REQ-002 SHALL have parameter CW, default 3: slot index width, equal to ceil(log2(N)).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 SHALL have port din, input, 1 bit: serial TDM data, one slot bit per valid cycle.
REQ-006 SHALL have port valid, input, 1 bit: din and frame_sync are sampled only when valid is high.
REQ-007 SHALL have port frame_sync, input, 1 bit: when high with valid, marks the current din as slot 0.
REQ-008 SHALL have port q, output, N bits: registered demultiplexed frame; slot i drives q[i].
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the cycle q takes a new frame.
REQ-010 SHALL have port sync_err, output, 1 bit: one-cycle pulse on a framing violation.
REQ-011 SHALL have port locked, output, 1 bit: high while the FSM is in RUN.
REQ-012 SHALL have port slot, output, CW bits: index of the next slot to be written.

Function
REQ-013 SHALL implement a two-state FSM with states HUNT and RUN.
REQ-014 In either state, valid with frame_sync SHALL write din to shadow[0], set slot to 1, and move to RUN.
REQ-015 In HUNT, valid without frame_sync SHALL be ignored; slot stays 0.
REQ-016 In RUN, valid without frame_sync and 0 < slot < N-1 SHALL write din to shadow[slot] and increment slot.
REQ-017 In RUN, valid without frame_sync and slot == N-1 SHALL load q with the shadow bits plus din as bit N-1 on the next edge, then set slot to 0.
REQ-018 In that case frame_done SHALL go high for exactly that cycle, so q is valid one cycle after the last slot bit is sampled.
REQ-019 In RUN, valid without frame_sync and slot == 0 (sync missing) SHALL pulse sync_err, move to HUNT, drop the bit, and leave q unchanged.
REQ-020 In RUN, valid with frame_sync and slot != 0 (early sync) SHALL pulse sync_err, drop the partial frame, and restart at slot 0 with the current din per REQ-014.
REQ-021 valid low SHALL hold slot, shadow, state and q unchanged, and frame_done and sync_err SHALL be low.
REQ-022 The slot index SHALL wrap from N-1 to 0 only on frame completion and SHALL never exceed N-1.
REQ-023 frame_done and sync_err SHALL never be high in the same cycle.
REQ-024 q SHALL change only on frame completion or reset; partial frames SHALL never be visible on q.

Reset
REQ-025 reset high SHALL on the next rising edge set state to HUNT, slot to 0, shadow to 0, q to 0, and frame_done, sync_err and locked to 0.
REQ-026 reset SHALL override all other inputs in the same cycle.
REQ-027 reset mid-frame SHALL discard the partial frame, and the next frame SHALL require frame_sync.

Structure
REQ-028 The shared package tdm_pkg SHALL hold the state encodings (HUNT=1'b0, RUN=1'b1) and the default N.
REQ-029 The slot index logic (load 0/1, increment, wrap) SHALL live in sub-module tdm_slot_counter; the FSM, shadow register and q register SHALL stay in tdm_demux.

Verification (N=8)
REQ-030 SHALL cover a normal frame: sync on bit 0, bits 1,0,1,1,0,0,1,0 in slots 0..7 -> q=8'h4D one cycle after slot 7, frame_done high 1 cycle, locked high.
REQ-031 SHALL cover back-to-back frames: 8'h4D then 8'hA5 with sync on each slot 0 and valid always high -> q=8'h4D then 8'hA5, two frame_done pulses 8 cycles apart, no sync_err.
REQ-032 SHALL cover early sync: sync at slot 5 of a frame, then a full 8'hFF frame -> sync_err pulse at slot 5, q unchanged until the 8'hFF frame completes, q=8'hFF.
REQ-033 SHALL cover missing sync: after a frame completes, next valid bit without sync -> sync_err pulse, locked low, q holds its last value, later bits ignored until sync.
REQ-034 SHALL cover valid gaps: the 8'h4D frame with valid low for 3 cycles between slots 3 and 4 -> q=8'h4D, slot held at 4 during the gap.
REQ-035 SHALL cover reset mid-frame: reset at slot 4, then a full 8'h3C frame -> all outputs 0 after reset, q=8'h3C only after the new frame, no spurious frame_done.
